inst_fetch_bridge: RTL and testbench
====================================

# inst_fetch_bridge

Instruction-fetch responder between the PC register and the instruction bus. It samples the fetch address and chip-enable produced each cycle by the PC stage and issues a single-outstanding read on the instruction bus. It returns the fetched word to the IF/ID stage and requests a pipeline stall while the bus is busy. Flushes from jumps or interrupts cancel in-flight fetches, and a wait counter turns a hung bus into a reported error.

## Interface
- `ADDR_WIDTH`, `` `ADDR_WIDTH `` (32): fetch address width.
- `INST_WIDTH`, 32: instruction word width.
- `MAX_WAIT`, 255: cycles without ack before a bus timeout; counter width is clog2(MAX_WAIT+1).

- `clk_i` input 1: single clock; everything updates on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `pc_i` input ADDR_WIDTH: fetch address from the PC stage.
- `ce_i` input 1: fetch enable from the PC stage; 0 means no fetch.
- `flush_i` input 1: jump or interrupt flush (OR of both sources).
- `stall_i` input 6: pipeline stall vector; bit 1 == `` `STOP `` freezes IF/ID.
- `ibus_req_o` output 1: bus read request.
- `ibus_addr_o` output ADDR_WIDTH: bus read address.
- `ibus_ack_i` input 1: bus data valid; a one-cycle pulse.
- `ibus_data_i` input INST_WIDTH: bus read data.
- `inst_o` output INST_WIDTH: instruction to IF/ID.
- `inst_valid_o` output 1: `inst_o` holds a live instruction.
- `stall_req_o` output 1: fetch-busy stall request to ctrl.
- `misalign_o` output 1: one-cycle pulse on a misaligned PC.
- `bus_err_o` output 1: one-cycle pulse on a bus timeout.

## Operation
- Reset values: state IDLE, `ibus_req_o`=0, `ibus_addr_o`=0, `inst_o`=`` `NOP_INST `` (32'h00000013), `inst_valid_o`=0, `stall_req_o`=0, `misalign_o`=0, `bus_err_o`=0, wait counter 0.
- **IDLE**
  - If `ce_i`=1, `pc_i[1:0]`=0 and `flush_i`=0: latch `ibus_addr_o`<=`pc_i`, `ibus_req_o`<=1, clear the counter, go to REQ.
  - If `ce_i`=1 and `pc_i[1:0]`≠0: no request; `misalign_o` pulses; `inst_o`<=NOP; `inst_valid_o`<=0.
  - If `ce_i`=0: `inst_valid_o`<=0.
- **REQ**
  - `ibus_req_o` and `ibus_addr_o` stay stable until ack (bus rule).
  - On ack with no flush: `inst_o`<=`ibus_data_i`, `inst_valid_o`<=1, `ibus_req_o`<=0.
  - After that ack, go to HOLD if `stall_i[1]`==`` `STOP ``, else IDLE.
- **HOLD**
  - `inst_o` and `inst_valid_o` frozen while `stall_i[1]`==`` `STOP ``.
  - Release goes to IDLE; a new fetch may be issued in that same release cycle.
- **DISCARD**
  - Entered from REQ on `flush_i`=1 without ack.
  - `ibus_req_o` held until ack; the data is dropped and the state returns to IDLE.
  - `inst_valid_o`=0 throughout.
- **Flush**
  - Flush and ack together in REQ: the data is dropped, `ibus_req_o`<=0, go to IDLE, `inst_valid_o`<=0.
  - Flush in HOLD: go to IDLE, `inst_o`<=NOP, `inst_valid_o`<=0.
  - Flush always wins over stall.
- **Timeout**
  - The counter increments each REQ/DISCARD cycle without ack.
  - At MAX_WAIT: `ibus_req_o`<=0 and go to IDLE.
  - From REQ it also pulses `bus_err_o` and sets `inst_o`<=NOP, `inst_valid_o`<=0; from DISCARD it exits silently.
- `stall_req_o` = (state==REQ | state==DISCARD), registered with the state.
- Reset mid-transaction returns everything to reset values; a late ack in IDLE is ignored.

## Timing
- Cycle N: IDLE and a valid `pc_i`/`ce_i` are sampled. Cycle N+1: `ibus_req_o`=1 and `stall_req_o`=1.
- Ack in cycle M: `inst_o`/`inst_valid_o` are updated and `stall_req_o`=0 from cycle M+1.
- Zero-wait bus (ack in N+1): instruction valid at N+2, so minimum fetch latency is 2 cycles.
- Throughput is one fetch per 2 cycles; only one request is outstanding.
- Ack is sampled only in REQ/DISCARD.

## Structure
- `` `ADDR_WIDTH ``, `` `INST_WIDTH ``, `` `NOP_INST `` and `` `STOP `` live in the shared defines.v.
- The state encodings (IDLE/REQ/HOLD/DISCARD, 2-bit) are local parameters.
- No sub-module is needed; the timeout counter stays inline.

## Test plan
- **Zero-wait fetch:** reset, `pc_i`=0x0, `ce_i`=1; ack in the cycle after request with data 0x00500093.
  - `inst_o`=0x00500093 and `inst_valid_o`=1 two cycles after sampling.
  - `stall_req_o` high exactly one cycle.
- **3-wait fetch:** `pc_i`=0x100; ack on the 4th request cycle.
  - `ibus_addr_o`=0x100 stable throughout.
  - `stall_req_o` high 4 cycles.
- **Flush in flight:** flush at request cycle 1, ack 2 cycles later.
  - State goes DISCARD; the data is dropped.
  - `inst_valid_o`=0; next fetch uses the new `pc_i`.
- **Simultaneous flush and ack:** the data is not delivered and the state returns to IDLE.
- **Stall hold and misalign:**
  - Ack while `stall_i[1]`=1 for 3 cycles: `inst_o` held 3 cycles, then IDLE.
  - `pc_i`=0x102: `misalign_o` pulse, no `ibus_req_o`.
- **Timeout:** MAX_WAIT=4, no ack.
  - `bus_err_o` pulses after 4 request cycles; `ibus_req_o` drops; `inst_o`=NOP.
  - Reset asserted mid-REQ clears everything.

Source files
------------

// File: rtl/inst_fetch_bridge_pkg.sv
// Shared constants and state type for the instruction-fetch bridge.
// NOP_INST is the RISC-V canonical NOP (addi x0, x0, 0).
package inst_fetch_bridge_pkg;

    localparam int          DEF_ADDR_WIDTH = 32;
    localparam int          DEF_INST_WIDTH = 32;
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam logic        STOP           = 1'b1;
    localparam int          STALL_IF_ID    = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_bridge.sv
// Single-outstanding instruction-fetch responder between the PC stage and the
// instruction bus, with flush cancellation and a bus-timeout watchdog.
//
// state   | meaning
// IDLE    | no read outstanding; may issue a fetch this cycle
// REQ     | read outstanding, result will be delivered to IF/ID
// HOLD    | delivered instruction frozen while IF/ID is stalled
// DISCARD | read outstanding after a flush; result will be dropped
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  ce_i,
    input  logic                  flush_i,
    input  logic [5:0]            stall_i,
    output logic                  ibus_req_o,
    output logic [ADDR_WIDTH-1:0] ibus_addr_o,
    input  logic                  ibus_ack_i,
    input  logic [INST_WIDTH-1:0] ibus_data_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  inst_valid_o,
    output logic                  stall_req_o,
    output logic                  misalign_o,
    output logic                  bus_err_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [INST_WIDTH-1:0] NOP_W = INST_WIDTH'(NOP_INST);

    fetch_state_t          state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  stall_q, stall_d;
    logic                  mis_q, mis_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  accept_fetch;
    logic                  if_id_stop;
    logic                  timeout;
    logic                  unused_stall_bits;

    assign if_id_stop        = (stall_i[STALL_IF_ID] == STOP);
    // This cycle is the MAX_WAIT-th one without ack.
    assign timeout           = (cnt_q == CW'(MAX_WAIT - 1));
    assign unused_stall_bits = ^{stall_i[5:2], stall_i[0]};

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        inst_d       = inst_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        mis_d        = 1'b0;
        err_d        = 1'b0;
        accept_fetch = 1'b0;

        case (state_q)
            S_IDLE: accept_fetch = 1'b1;
            S_HOLD: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    inst_d  = NOP_W;
                    valid_d = 1'b0;
                end else if (!if_id_stop) begin
                    accept_fetch = 1'b1;
                end
            end
            S_REQ: begin
                if (ibus_ack_i) begin
                    req_d = 1'b0;
                    if (flush_i) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        inst_d  = ibus_data_i;
                        valid_d = 1'b1;
                        state_d = if_id_stop ? S_HOLD : S_IDLE;
                    end
                end else if (timeout) begin
                    // A flush on the timeout cycle already cancelled the fetch.
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    if (!flush_i) begin
                        err_d  = 1'b1;
                        inst_d = NOP_W;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    valid_d = 1'b0;
                    if (flush_i) state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                valid_d = 1'b0;
                if (ibus_ack_i || timeout) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept_fetch) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            if (ce_i) begin
                if (pc_i[1:0] != 2'b00) begin
                    mis_d  = 1'b1;
                    inst_d = NOP_W;
                end else if (!flush_i) begin
                    addr_d  = pc_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
        end

        stall_d = (state_d == S_REQ) || (state_d == S_DISCARD);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            inst_q  <= NOP_W;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ibus_req_o   = req_q;
    assign ibus_addr_o  = addr_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign stall_req_o  = stall_q;
    assign misalign_o   = mis_q;
    assign bus_err_o    = err_q;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Testbench for inst_fetch_bridge: directed vector table, reset corner case,
// then randomized traffic against a transaction-level reference model.
module tb_inst_fetch_bridge;

    localparam int          MW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ce, flush, ack;
    logic [5:0]  stall;
    logic [31:0] data;
    logic        req, valid, stall_req, mis, err;
    logic [31:0] addr, inst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch_bridge #(.ADDR_WIDTH(32), .INST_WIDTH(32), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .ce_i(ce), .flush_i(flush),
        .stall_i(stall), .ibus_req_o(req), .ibus_addr_o(addr),
        .ibus_ack_i(ack), .ibus_data_i(data), .inst_o(inst),
        .inst_valid_o(valid), .stall_req_o(stall_req), .misalign_o(mis),
        .bus_err_o(err)
    );

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic        flush;
        logic [5:0]  stall;
        logic        ack;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_stall;
        logic        e_mis;
        logic        e_err;
    } vec_t;

    vec_t vt[31];

    // Reference model: one outstanding read, tracked as a transaction.
    bit          m_pending, m_cancel, m_frozen;
    int          m_waited;
    logic        x_req, x_valid, x_stall, x_mis, x_err;
    logic [31:0] x_addr, x_inst;

    task automatic model_reset();
        m_pending = 0; m_cancel = 0; m_frozen = 0; m_waited = 0;
        x_req = 0; x_valid = 0; x_stall = 0; x_mis = 0; x_err = 0;
        x_addr = 0; x_inst = NOP;
    endtask

    task automatic model_step(input logic c, input logic [31:0] p, input logic f,
                              input logic s1, input logic a, input logic [31:0] d);
        x_mis = 0; x_err = 0;
        if (m_pending) begin
            x_valid = 0;
            if (a) begin
                m_pending = 0; x_req = 0;
                if (!m_cancel && !f) begin
                    x_inst = d; x_valid = 1; m_frozen = s1;
                end
            end else begin
                m_waited++;
                if (f) m_cancel = 1;
                if (m_waited == MW) begin
                    m_pending = 0; x_req = 0;
                    if (!m_cancel) begin x_err = 1; x_inst = NOP; end
                end
            end
        end else if (m_frozen && f) begin
            m_frozen = 0; x_inst = NOP; x_valid = 0;
        end else if (!(m_frozen && s1)) begin
            m_frozen = 0; x_valid = 0;
            if (c) begin
                if (p[1:0] != 2'b00) begin
                    x_mis = 1; x_inst = NOP;
                end else if (!f) begin
                    m_pending = 1; m_cancel = 0; m_waited = 0;
                    x_req = 1; x_addr = p;
                end
            end
        end
        x_stall = m_pending;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic [31:0] e_inst, input logic e_valid,
                           input logic e_stall, input logic e_mis, input logic e_err);
        chk({tag, ".req"},   {31'b0, req},       {31'b0, e_req});
        chk({tag, ".addr"},  addr,               e_addr);
        chk({tag, ".inst"},  inst,               e_inst);
        chk({tag, ".valid"}, {31'b0, valid},     {31'b0, e_valid});
        chk({tag, ".stall"}, {31'b0, stall_req}, {31'b0, e_stall});
        chk({tag, ".mis"},   {31'b0, mis},       {31'b0, e_mis});
        chk({tag, ".err"},   {31'b0, err},       {31'b0, e_err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ce pc flush stall ack data | req addr inst valid stall mis err
        vt[0]  = '{1, 32'h000, 0, 6'h0, 0, 32'h0,        1, 32'h000, NOP,          0, 1, 0, 0};
        vt[1]  = '{0, 32'h000, 0, 6'h0, 1, 32'h00500093, 0, 32'h000, 32'h00500093, 1, 0, 0, 0};
        vt[2]  = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        0, 32'h000, 32'h00500093, 0, 0, 0, 0};
        vt[3]  = '{1, 32'h100, 0, 6'h0, 0, 32'h0,        1, 32'h100, 32'h00500093, 0, 1, 0, 0};
        vt[4]  = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        1, 32'h100, 32'h00500093, 0, 1, 0, 0};
        vt[5]  = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        1, 32'h100, 32'h00500093, 0, 1, 0, 0};
        vt[6]  = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        1, 32'h100, 32'h00500093, 0, 1, 0, 0};
        vt[7]  = '{0, 32'h000, 0, 6'h0, 1, 32'h00a00113, 0, 32'h100, 32'h00a00113, 1, 0, 0, 0};
        vt[8]  = '{1, 32'h102, 0, 6'h0, 0, 32'h0,        0, 32'h100, NOP,          0, 0, 1, 0};
        vt[9]  = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        0, 32'h100, NOP,          0, 0, 0, 0};
        vt[10] = '{1, 32'h200, 0, 6'h0, 0, 32'h0,        1, 32'h200, NOP,          0, 1, 0, 0};
        vt[11] = '{0, 32'h000, 0, 6'h2, 1, 32'h12345678, 0, 32'h200, 32'h12345678, 1, 0, 0, 0};
        vt[12] = '{1, 32'h204, 0, 6'h2, 0, 32'h0,        0, 32'h200, 32'h12345678, 1, 0, 0, 0};
        vt[13] = '{0, 32'h000, 0, 6'h2, 0, 32'h0,        0, 32'h200, 32'h12345678, 1, 0, 0, 0};
        vt[14] = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        0, 32'h200, 32'h12345678, 0, 0, 0, 0};
        vt[15] = '{1, 32'h300, 0, 6'h0, 0, 32'h0,        1, 32'h300, 32'h12345678, 0, 1, 0, 0};
        vt[16] = '{0, 32'h000, 1, 6'h0, 0, 32'h0,        1, 32'h300, 32'h12345678, 0, 1, 0, 0};
        vt[17] = '{1, 32'h380, 0, 6'h0, 0, 32'h0,        1, 32'h300, 32'h12345678, 0, 1, 0, 0};
        vt[18] = '{0, 32'h000, 0, 6'h0, 1, 32'h00000bad, 0, 32'h300, 32'h12345678, 0, 0, 0, 0};
        vt[19] = '{1, 32'h400, 0, 6'h0, 0, 32'h0,        1, 32'h400, 32'h12345678, 0, 1, 0, 0};
        vt[20] = '{0, 32'h000, 1, 6'h0, 1, 32'hcafef00d, 0, 32'h400, 32'h12345678, 0, 0, 0, 0};
        vt[21] = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        0, 32'h400, 32'h12345678, 0, 0, 0, 0};
        vt[22] = '{1, 32'h500, 0, 6'h0, 0, 32'h0,        1, 32'h500, 32'h12345678, 0, 1, 0, 0};
        vt[23] = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        1, 32'h500, 32'h12345678, 0, 1, 0, 0};
        vt[24] = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        1, 32'h500, 32'h12345678, 0, 1, 0, 0};
        vt[25] = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        1, 32'h500, 32'h12345678, 0, 1, 0, 0};
        vt[26] = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        0, 32'h500, NOP,          0, 0, 0, 1};
        vt[27] = '{0, 32'h000, 0, 6'h0, 0, 32'h0,        0, 32'h500, NOP,          0, 0, 0, 0};
        vt[28] = '{1, 32'h600, 0, 6'h0, 0, 32'h0,        1, 32'h600, NOP,          0, 1, 0, 0};
        vt[29] = '{0, 32'h000, 0, 6'h2, 1, 32'h00000033, 0, 32'h600, 32'h00000033, 1, 0, 0, 0};
        vt[30] = '{0, 32'h000, 1, 6'h2, 0, 32'h0,        0, 32'h600, NOP,          0, 0, 0, 0};

        rst = 1; pc = 0; ce = 0; flush = 0; stall = 0; ack = 0; data = 0;
        tick(); tick();
        chk_all("reset", 0, 0, NOP, 0, 0, 0, 0);
        rst = 0;

        for (int i = 0; i < 31; i++) begin
            ce = vt[i].ce; pc = vt[i].pc; flush = vt[i].flush;
            stall = vt[i].stall; ack = vt[i].ack; data = vt[i].data;
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_inst,
                    vt[i].e_valid, vt[i].e_stall, vt[i].e_mis, vt[i].e_err);
        end

        // Reset in the middle of an outstanding read, then a late ack in IDLE.
        ce = 1; pc = 32'h700; flush = 0; stall = 0; ack = 0;
        tick();
        ce = 0;
        tick();
        chk("midreq.req", {31'b0, req}, 32'd1);
        rst = 1;
        tick();
        chk_all("rst_midreq", 0, 0, NOP, 0, 0, 0, 0);
        rst = 0; ack = 1; data = 32'h11111111;
        tick();
        chk_all("late_ack", 0, 0, NOP, 0, 0, 0, 0);
        ack = 0;

        model_reset();
        for (int n = 0; n < 3000; n++) begin
            ce    = ($urandom_range(0, 99) < 60);
            pc    = {$urandom_range(0, 32'hFFFF), 2'b00, 14'h0} | ($urandom_range(0, 63) << 2);
            if ($urandom_range(0, 99) < 15) pc[1:0] = 2'($urandom_range(1, 3));
            flush = ($urandom_range(0, 99) < 10);
            stall = 6'($urandom_range(0, 63));
            stall[1] = ($urandom_range(0, 99) < 30);
            ack   = m_pending ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
            data  = $urandom;
            model_step(ce, pc, flush, stall[1], ack, data);
            tick();
            chk_all($sformatf("rnd%0d", n), x_req, x_addr, x_inst, x_valid, x_stall, x_mis, x_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
